// File: rtl/alu_counter_register_if.sv
// Purpose : control/bus bundle between the SAP sequencer (master) and the datapath core (slave).
// Latency : n/a (wires only).
// Backpress: none; the sequencer owns every control bit each cycle.
// Signals : i_bus resolved bus in; i_ai/i_bi/i_ii/i_j load strobes; i_ao/i_bo/i_io/i_co/i_eo
//           output enables; i_ce PC count; i_su ALU subtract; i_fi flags load; o_bus/o_bus_en muxed
//           bus out; o_reg_a/o_reg_b/o_instr/o_pc/o_flags direct register views.
interface alu_counter_register_if #(
  parameter int WIDTH    = 8,
  parameter int PC_WIDTH = 4
);
  logic [WIDTH-1:0]    i_bus;
  logic                i_ai;
  logic                i_ao;
  logic                i_bi;
  logic                i_bo;
  logic                i_ii;
  logic                i_io;
  logic                i_j;
  logic                i_co;
  logic                i_ce;
  logic                i_eo;
  logic                i_su;
  logic                i_fi;
  logic [WIDTH-1:0]    o_bus;
  logic                o_bus_en;
  logic [WIDTH-1:0]    o_reg_a;
  logic [WIDTH-1:0]    o_reg_b;
  logic [WIDTH-1:0]    o_instr;
  logic [PC_WIDTH-1:0] o_pc;
  logic [1:0]          o_flags;

  modport master (
    output i_bus, i_ai, i_ao, i_bi, i_bo, i_ii, i_io, i_j, i_co, i_ce, i_eo, i_su, i_fi,
    input  o_bus, o_bus_en, o_reg_a, o_reg_b, o_instr, o_pc, o_flags
  );

  modport slave (
    input  i_bus, i_ai, i_ao, i_bi, i_bo, i_ii, i_io, i_j, i_co, i_ce, i_eo, i_su, i_fi,
    output o_bus, o_bus_en, o_reg_a, o_reg_b, o_instr, o_pc, o_flags
  );
endinterface

// File: rtl/alu_counter_register.sv
// Purpose : SAP-style datapath core: A, B, IR, flags, PC registers plus add/sub ALU and bus mux.
// Latency : register loads visible one cycle after the enabling edge; ALU and o_bus are combinational.
// Backpress: none; every control bit is obeyed on the cycle it is asserted.
// Ports   : i_clk system clock, i_rst async active-high reset, bus_if slave side of the control bundle.
module alu_counter_register #(
  parameter int WIDTH    = 8,
  parameter int PC_WIDTH = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  alu_counter_register_if.slave bus_if
);

  // IR drives only its operand field onto the bus.
  localparam int OPND_WIDTH = 4;

  logic [WIDTH-1:0]    reg_a;
  logic [WIDTH-1:0]    reg_b;
  logic [WIDTH-1:0]    reg_ir;
  logic [PC_WIDTH-1:0] reg_pc;
  logic [1:0]          reg_flags;

  logic [WIDTH-1:0]    alu_b;
  logic [WIDTH:0]      alu_sum;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_c;
  logic                alu_z;

  // Subtract is two's complement: A + ~B + 1, so carry-out set means no borrow.
  always_comb begin
    alu_b   = bus_if.i_su ? ~reg_b : reg_b;
    alu_sum = {1'b0, reg_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, bus_if.i_su};
    alu_res = alu_sum[WIDTH-1:0];
    alu_c   = alu_sum[WIDTH];
    alu_z   = (alu_res == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      reg_a     <= '0;
      reg_b     <= '0;
      reg_ir    <= '0;
      reg_flags <= '0;
      reg_pc    <= '0;
    end else begin
      if (bus_if.i_ai) reg_a  <= bus_if.i_bus;
      if (bus_if.i_bi) reg_b  <= bus_if.i_bus;
      if (bus_if.i_ii) reg_ir <= bus_if.i_bus;
      if (bus_if.i_fi) reg_flags <= {alu_c, alu_z};
      // Jump beats count when both are asserted.
      if (bus_if.i_j)       reg_pc <= bus_if.i_bus[PC_WIDTH-1:0];
      else if (bus_if.i_ce) reg_pc <= reg_pc + 1'b1;
    end
  end

  // Fixed priority EO > AO > BO > IO > CO; drives zero when nothing is enabled.
  always_comb begin
    bus_if.o_bus = '0;
    if (bus_if.i_eo)      bus_if.o_bus = alu_res;
    else if (bus_if.i_ao) bus_if.o_bus = reg_a;
    else if (bus_if.i_bo) bus_if.o_bus = reg_b;
    else if (bus_if.i_io) bus_if.o_bus = {{(WIDTH-OPND_WIDTH){1'b0}}, reg_ir[OPND_WIDTH-1:0]};
    else if (bus_if.i_co) bus_if.o_bus = {{(WIDTH-PC_WIDTH){1'b0}}, reg_pc};
  end

  assign bus_if.o_bus_en = bus_if.i_eo | bus_if.i_ao | bus_if.i_bo | bus_if.i_io | bus_if.i_co;
  assign bus_if.o_reg_a  = reg_a;
  assign bus_if.o_reg_b  = reg_b;
  assign bus_if.o_instr  = reg_ir;
  assign bus_if.o_pc     = reg_pc;
  assign bus_if.o_flags  = reg_flags;

endmodule

// File: tb/tb_alu_counter_register.sv
// Purpose : directed self-checking bench for alu_counter_register.
// Latency : n/a.
// Backpress: n/a.
module tb_alu_counter_register;

  logic i_clk;
  logic i_rst;
  int   total;
  int   bad;

  alu_counter_register_if #(.WIDTH(8), .PC_WIDTH(4)) bus_if ();

  alu_counter_register #(.WIDTH(8), .PC_WIDTH(4)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .bus_if (bus_if)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic clr_ctrl();
    bus_if.i_ai = 0; bus_if.i_ao = 0; bus_if.i_bi = 0; bus_if.i_bo = 0;
    bus_if.i_ii = 0; bus_if.i_io = 0; bus_if.i_j  = 0; bus_if.i_co = 0;
    bus_if.i_ce = 0; bus_if.i_eo = 0; bus_if.i_su = 0; bus_if.i_fi = 0;
  endtask

  // Advance one rising edge and land 1 ns after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ld_a(input logic [7:0] v);
    bus_if.i_bus = v; bus_if.i_ai = 1; step(); bus_if.i_ai = 0;
  endtask
  task automatic ld_b(input logic [7:0] v);
    bus_if.i_bus = v; bus_if.i_bi = 1; step(); bus_if.i_bi = 0;
  endtask
  task automatic ld_ir(input logic [7:0] v);
    bus_if.i_bus = v; bus_if.i_ii = 1; step(); bus_if.i_ii = 0;
  endtask
  task automatic ld_pc(input logic [7:0] v);
    bus_if.i_bus = v; bus_if.i_j = 1; step(); bus_if.i_j = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr_ctrl();
    bus_if.i_bus = 8'h00;
    i_rst = 1'b1;
    #12;
    i_rst = 1'b0;
    #1;
    check("rst_a", bus_if.o_reg_a, 8'h00);
    check("rst_pc", {4'h0, bus_if.o_pc}, 8'h00);
    check("rst_flags", {6'h0, bus_if.o_flags}, 8'h00);
    check("rst_bus_en", {7'h0, bus_if.o_bus_en}, 8'h00);

    // Preload everything, then reset asynchronously mid-cycle.
    ld_a(8'h55);
    ld_b(8'h55);
    bus_if.i_su = 1; bus_if.i_fi = 1; step(); bus_if.i_su = 0; bus_if.i_fi = 0;
    ld_b(8'h66);
    ld_ir(8'h5A);
    ld_pc(8'h09);
    check("pre_a", bus_if.o_reg_a, 8'h55);
    check("pre_b", bus_if.o_reg_b, 8'h66);
    check("pre_ir", bus_if.o_instr, 8'h5A);
    check("pre_pc", {4'h0, bus_if.o_pc}, 8'h09);
    check("pre_flags", {6'h0, bus_if.o_flags}, 8'h03);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_a", bus_if.o_reg_a, 8'h00);
    check("arst_b", bus_if.o_reg_b, 8'h00);
    check("arst_ir", bus_if.o_instr, 8'h00);
    check("arst_pc", {4'h0, bus_if.o_pc}, 8'h00);
    check("arst_flags", {6'h0, bus_if.o_flags}, 8'h00);
    bus_if.i_ai = 1; bus_if.i_bus = 8'hFF;
    step();
    step();
    check("hold_rst_a", bus_if.o_reg_a, 8'h00);
    clr_ctrl();
    #2;
    i_rst = 1'b0;
    #1;

    // Addition and flags.
    ld_a(8'h28);
    ld_b(8'h0E);
    bus_if.i_eo = 1; bus_if.i_su = 0;
    #1;
    check("add_bus", bus_if.o_bus, 8'h36);
    check("add_bus_en", {7'h0, bus_if.o_bus_en}, 8'h01);
    bus_if.i_fi = 1; step(); bus_if.i_fi = 0;
    check("add_flags", {6'h0, bus_if.o_flags}, 8'h00);
    clr_ctrl();
    ld_a(8'hF0);
    ld_b(8'h10);
    bus_if.i_eo = 1;
    #1;
    check("add_wrap_bus", bus_if.o_bus, 8'h00);
    bus_if.i_fi = 1; step(); bus_if.i_fi = 0;
    check("add_wrap_flags", {6'h0, bus_if.o_flags}, 8'h03);
    clr_ctrl();

    // Subtraction.
    ld_a(8'h05);
    ld_b(8'h07);
    bus_if.i_su = 1; bus_if.i_eo = 1;
    #1;
    check("sub_bus", bus_if.o_bus, 8'hFE);
    bus_if.i_fi = 1; step(); bus_if.i_fi = 0;
    check("sub_flags", {6'h0, bus_if.o_flags}, 8'h00);
    clr_ctrl();
    ld_a(8'h07);
    bus_if.i_su = 1; bus_if.i_eo = 1;
    #1;
    check("sub_eq_bus", bus_if.o_bus, 8'h00);
    bus_if.i_fi = 1; step(); bus_if.i_fi = 0;
    check("sub_eq_flags", {6'h0, bus_if.o_flags}, 8'h03);
    clr_ctrl();
    // Flags hold when i_fi is low even though the ALU result changes.
    ld_a(8'h01);
    check("flags_hold", {6'h0, bus_if.o_flags}, 8'h03);

    // Program counter count and wrap, starting from 0 after reset.
    check("pc_start", {4'h0, bus_if.o_pc}, 8'h00);
    bus_if.i_ce = 1;
    for (int i = 1; i <= 17; i++) begin
      step();
      check($sformatf("pc_count_%0d", i), {4'h0, bus_if.o_pc}, 8'(i % 16));
    end
    bus_if.i_j = 1; bus_if.i_bus = 8'h3C;
    step();
    check("pc_jump_wins", {4'h0, bus_if.o_pc}, 8'h0C);
    clr_ctrl();

    // IR operand output.
    ld_ir(8'hE7);
    check("ir_load", bus_if.o_instr, 8'hE7);
    bus_if.i_io = 1;
    #1;
    check("ir_bus", bus_if.o_bus, 8'h07);
    clr_ctrl();

    // Bus contention priority.
    ld_a(8'h11);
    ld_b(8'h22);
    ld_pc(8'h03);
    bus_if.i_ao = 1; bus_if.i_bo = 1; bus_if.i_co = 1;
    #1;
    check("prio_ao", bus_if.o_bus, 8'h11);
    bus_if.i_ao = 0;
    #1;
    check("prio_bo", bus_if.o_bus, 8'h22);
    bus_if.i_bo = 0;
    #1;
    check("co_bus", bus_if.o_bus, 8'h03);
    bus_if.i_co = 0;
    #1;
    check("idle_bus", bus_if.o_bus, 8'h00);
    check("idle_bus_en", {7'h0, bus_if.o_bus_en}, 8'h00);

    // Load and output in the same cycle: bus shows old value, register takes new.
    bus_if.i_ao = 1; bus_if.i_ai = 1; bus_if.i_bus = 8'h99;
    #1;
    check("ld_out_old", bus_if.o_bus, 8'h11);
    step();
    check("ld_out_new", bus_if.o_reg_a, 8'h99);
    clr_ctrl();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_counter_register.md
Name: alu_counter_register

Overview:
- Datapath core of the 8-bit SAP-style CPU.
- Contains:
  - 8-bit A register.
  - 8-bit B register.
  - 8-bit instruction register (IR).
  - 2-bit flags register.
  - 4-bit program counter (PC).
  - 8-bit add/subtract ALU.
- The top-level sequencer drives the control bits. The shared system bus is split into a bus input (i_bus) and a muxed bus output (o_bus, with valid flag o_bus_en). The top level resolves the bus and feeds it back on i_bus.

Parameters:
- WIDTH, 8, data width of the A, B and IR registers, the ALU and the bus.
- PC_WIDTH, 4, program counter width; upper bus bits are zero when the PC drives the bus.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_bus  in  8  resolved system bus value; the source for all loads.
- i_ai  in  1  load A from i_bus.
- i_ao  in  1  drive A onto o_bus.
- i_bi  in  1  load B from i_bus.
- i_bo  in  1  drive B onto o_bus.
- i_ii  in  1  load IR from i_bus.
- i_io  in  1  drive IR low nibble onto o_bus (upper nibble 0).
- i_j  in  1  load PC from i_bus[3:0] (jump).
- i_co  in  1  drive PC onto o_bus.
- i_ce  in  1  increment PC.
- i_eo  in  1  drive ALU result onto o_bus.
- i_su  in  1  ALU subtract select.
- i_fi  in  1  load flags from the ALU.
- o_bus  out  8  selected bus source value; 0 when none is enabled.
- o_bus_en  out  1  high when any output enable is active.
- o_reg_a  out  8  A contents (direct).
- o_reg_b  out  8  B contents (direct).
- o_instr  out  8  IR contents (direct).
- o_pc  out  4  PC contents.
- o_flags  out  2  flags contents: [1] = carry C, [0] = zero Z.

Behaviour:
- Reset (i_rst high, asynchronous):
  - A, B, IR, flags and PC clear to 0.
  - This holds immediately and for as long as i_rst stays high; all control inputs are ignored.
  - Reset mid-operation aborts any pending load or count.
- Registers A, B, IR:
  - On a rising edge with the load bit high: Q <= i_bus. Otherwise hold.
  - Load and output enable may both be high in the same cycle. o_bus then shows the old Q, and Q takes i_bus at the edge.
- IR bus output: o_bus = {4'b0, IR[3:0]} (operand field only).
- Program counter:
  - On a rising edge, i_j has priority: PC <= i_bus[3:0].
  - Otherwise, if i_ce is high: PC <= PC + 1, modulo 16 (15 wraps to 0).
  - Otherwise hold.
  - Bus output = {4'b0, PC}.
- ALU, combinational on the current A and B, result 8 bits:
  - i_su=0: sum = A + B (9-bit). Result = sum[7:0]; C = sum[8].
  - i_su=1: sum = A + ~B + 1 (9-bit). Result = sum[7:0]; C = sum[8], so C=1 means no borrow (A >= B unsigned).
  - Z = (result == 0).
- Flags register: on a rising edge with i_fi high, flags <= {C, Z} of the current ALU output. Otherwise hold; the flags are not affected by other operations.
- Bus output mux:
  - Fixed priority when several enables are high: EO > AO > BO > IO > CO.
  - o_bus_en = OR of i_eo, i_ao, i_bo, i_io, i_co.
  - o_bus = 0 when o_bus_en is low.
- No internal tri-states. All outputs are glitch-free functions of registers and control inputs; o_bus is combinational.
- Latency: loads visible on the direct outputs one cycle after the enabling edge. ALU outputs are zero-latency.

Test Plan:
- Reset: load A=0x55, B=0x66, IR=0x5A, PC=9, flags=3, then pulse i_rst high between edges -> all outputs read 0 without a clock edge. They stay 0 while i_rst is high, even with i_ai=1 and i_bus=0xFF.
- Add with flags: A=0x28, B=0x0E, i_eo=1, i_su=0 -> o_bus=0x36, o_bus_en=1. With i_fi=1 and one edge -> o_flags=2'b00. Then A=0xF0, B=0x10 -> o_bus=0x00, and after an i_fi edge o_flags=2'b11.
- Subtract: A=0x05, B=0x07, i_su=1, i_eo=1 -> o_bus=0xFE. After an i_fi edge o_flags=2'b00. Then A=B=0x07 -> o_bus=0x00; flags after an i_fi edge = 2'b11.
- PC: i_ce held for 17 edges from 0 -> o_pc sequence 1..15, 0, 1. With i_j=1, i_ce=1 and i_bus=0x3C on one edge -> o_pc=0xC (load wins).
- IR operand output: load IR with 0xE7 -> o_instr=0xE7. With i_io=1 -> o_bus=0x07.
- Bus contention: i_ao, i_bo and i_co high with A=0x11, B=0x22, PC=3 -> o_bus=0x11. Dropping i_ao -> o_bus=0x22. With no enables high -> o_bus=0x00, o_bus_en=0.
